// File: rtl/johnson_sequencer_pkg.sv
// Shared types and helpers for the Johnson sequencer.
//   state_t     : 2-bit FSM state encoding
//   DIR_FWD/REV : direction encodings for the dir input
//   is_johnson  : 1 when a code lies on the Johnson ring of width w
package johnson_sequencer_pkg;

  localparam int MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Walk the ring forward from zero and look for a match. Bits above w
  // are masked off, so narrower widths can share the 8-bit datapath.
  function automatic logic is_johnson(input logic [MAX_W-1:0] code,
                                      input int unsigned w);
    logic [MAX_W-1:0] v;
    logic [MAX_W-1:0] mask;
    logic             hit;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) if (i < int'(w)) mask[i] = 1'b1;
    v   = '0;
    hit = 1'b0;
    for (int i = 0; i < 2*MAX_W; i++) begin
      if (i < int'(2*w)) begin
        if (v == (code & mask) && (code & ~mask) == '0) hit = 1'b1;
        v = ((v << 1) | {{(MAX_W-1){1'b0}}, ~v[w-1]}) & mask;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/johnson_sequencer_phase_core.sv
// Phase register of the Johnson ring and its next-state logic.
//   clk, reset : clock, async active-low reset (already synchronised)
//   advance    : move one phase in direction dir
//   dir        : DIR_FWD / DIR_REV
//   load       : write load_val (caller guarantees it is a legal code)
//   phase_q    : current phase code
module johnson_phase_core
  import johnson_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] phase_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      phase_q <= '0;
    else if (load)
      phase_q <= load_val;
    else if (advance) begin
      if (dir == DIR_FWD) phase_q <= {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
      else                phase_q <= {~phase_q[0], phase_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/johnson_sequencer.sv
// Johnson-ring phase sequencer: runs run_len advances either freely
// (one per cycle) or gated by step pulses, with abort, load and a sticky
// illegal-load error flag.
//   clk, reset            : clock, async active-low reset
//   start/stop            : begin / abort a run
//   step_mode, step       : stepped operation and its strobe
//   dir, run_len          : direction and advance count, latched at start
//   load, load_val        : phase preload (IDLE only)
//   clear_err             : clears err
//   phase_q, phase_idx    : phase code and its ring index
//   busy, done, err       : status
module johnson_sequencer
  import johnson_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step,
  input  logic             dir,
  input  logic [7:0]       run_len,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_err,
  output logic [WIDTH-1:0] phase_q,
  output logic [3:0]       phase_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Assert asynchronously, release two edges after reset rises.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  state_t     state;
  logic [7:0] cnt;
  logic       dir_l;
  logic       advance;
  logic       ld;
  logic       ld_legal;
  logic [WIDTH-1:0] ld_val;

  assign ld       = (state == IDLE) && load;
  assign ld_legal = is_johnson(MAX_W'(load_val), WIDTH);
  assign ld_val   = ld_legal ? load_val : '0;

  // stop beats any advance in the same cycle
  assign advance = !stop && ((state == RUN) || (state == STEP_WAIT && step));
  assign busy    = (state == RUN) || (state == STEP_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir_l <= DIR_FWD;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // done trails DONE by one edge so the pulse lands N+1 cycles after start
      done <= (state == DONE);

      if (ld && !ld_legal) err <= 1'b1;
      else if (clear_err)  err <= 1'b0;

      case (state)
        IDLE: begin
          if (!load && start && !stop) begin
            cnt   <= run_len;
            dir_l <= dir;
            if (run_len == 8'd0) state <= DONE;
            else if (step_mode)  state <= STEP_WAIT;
            else                 state <= RUN;
          end
        end
        RUN, STEP_WAIT: begin
          if (stop)
            state <= IDLE;
          else if (advance) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  johnson_phase_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (rst_n),
    .advance  (advance),
    .dir      (dir_l),
    .load     (ld),
    .load_val (ld_val),
    .phase_q  (phase_q)
  );

  // Register only ever holds legal codes: below the half-way point the index
  // is the number of ones, past it the ones drain from the bottom.
  logic [3:0] ones;
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) ones = ones + 4'(phase_q[i]);
    phase_idx = phase_q[WIDTH-1] ? (4'(2*WIDTH) - ones) : ones;
  end

endmodule
